// File: rtl/y86_mem_pkg.sv
// Shared types and defaults for the Y86-64 data-memory access controller.
// Port indices double as the round-robin pointer encoding.
package y86_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam int unsigned AW_DEF         = 13;
  localparam logic [63:0] ADDR_LIMIT_DEF = 64'd258;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to
// the port named by ptr. The owner of ptr advances it on every grant.
module rr_arb2
  import y86_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (ptr == PORT_AUX) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Serialises two requesters onto the single-port data RAM, one transaction
// in flight, with a fixed read latency and out-of-range address trapping.
module dmem_access_ctrl
  import y86_mem_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter logic [63:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int          RD_LAT     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [63:0]   p0_addr,
  input  logic [63:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [63:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [63:0]   p1_addr,
  input  logic [63:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [63:0]   p1_rdata,
  output logic          p1_err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [63:0]   ram_wdata,
  input  logic [63:0]   ram_rdata,
  output logic [2:0]    dbg_state
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("dmem_access_ctrl: RD_LAT must be within 1..7");
  end

  state_e          state_q, state_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     rdata_q, rdata_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [1:0]      gnt;
  logic [63:0]     sel_addr;

  // Handshake: a requester holds req with we/addr/wdata stable until it sees
  // gnt high; the fields are captured on that edge. Exactly one rvalid pulse
  // (with err) follows on the same port. Grants are only issued from IDLE.
  rr_arb2 u_arb (
    .req ({p1_req, p0_req}),
    .en  ((state_q == ST_IDLE) && rst_n),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign sel_addr = gnt[1] ? p1_addr : p0_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      port_q   <= PORT_MEM;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= PORT_MEM;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          port_d   = gnt[1];
          we_d     = gnt[1] ? p1_we : p0_we;
          addr_d   = sel_addr[AW-1:0];
          wdata_d  = gnt[1] ? p1_wdata : p0_wdata;
          rr_ptr_d = ~gnt[1];
          // Range check uses the full 64-bit address, not the truncated RAM index.
          state_d  = (sel_addr >= ADDR_LIMIT) ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d   = 3'(RD_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          rdata_d = we_q ? 64'd0 : ram_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    p0_rvalid = 1'b0;
    p0_rdata  = '0;
    p0_err    = 1'b0;
    p1_rvalid = 1'b0;
    p1_rdata  = '0;
    p1_err    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      ST_ACCESS: begin
        ram_en    = 1'b1;
        ram_we    = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
      end
      ST_RESP: begin
        if (port_q == PORT_MEM) begin
          p0_rvalid = 1'b1;
          p0_rdata  = rdata_q;
        end else begin
          p1_rvalid = 1'b1;
          p1_rdata  = rdata_q;
        end
      end
      ST_ERR: begin
        if (port_q == PORT_MEM) begin
          p0_rvalid = 1'b1;
          p0_err    = 1'b1;
        end else begin
          p1_rvalid = 1'b1;
          p1_err    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random two-port traffic,
// checked by a grant/response reference model and per-port expected queues.
module tb_dmem_access_ctrl;
  import y86_mem_pkg::*;

  localparam int          LAT   = 3;
  localparam logic [63:0] LIMIT = 64'd258;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [63:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [63:0] ram_wdata, ram_rdata;
  logic [2:0]  dbg_state;

  dmem_access_ctrl #(.AW(13), .ADDR_LIMIT(LIMIT), .RD_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_val(input int k);
    return (64'(k) * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_0000_5A5A_FFFF;
  endfunction

  // ---------------- RAM model (junk on ram_rdata except when a read lands) ----------------
  logic [63:0] ram  [0:8191];
  logic [63:0] pipe [0:LAT-1];
  assign ram_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8192; k++) ram[k] <= init_val(k);
    end else if (ram_en && ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : {$urandom, $urandom};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q0[$], exp_q1[$];   // {err, rdata}
  int          due_q0[$], due_q1[$];
  logic [77:0] acc_q[$];               // {we, ram_addr, wdata}
  int          acc_due_q[$];
  logic [63:0] ref_mem [0:257];
  int          rr = 0, busy = 0, n_legal = 0, n_ram_en = 0;

  task automatic mon_port(input int p, input logic rv, input logic [63:0] rd, input logic er);
    logic [64:0] e;
    int d;
    int sz;
    sz = (p == 0) ? exp_q0.size() : exp_q1.size();
    if (rv) begin
      if (sz == 0) begin
        check($sformatf("p%0d_spurious_rvalid", p), 96'(rv), 96'd0);
      end else begin
        if (p == 0) begin e = exp_q0.pop_front(); d = due_q0.pop_front(); end
        else        begin e = exp_q1.pop_front(); d = due_q1.pop_front(); end
        check($sformatf("p%0d_resp", p), 96'({er, rd}), 96'(e));
        check($sformatf("p%0d_latency", p), 96'(cyc), 96'(d));
      end
    end else begin
      check($sformatf("p%0d_idle_zero", p), 96'({er, rd}), 96'd0);
      if (sz != 0) begin
        d = (p == 0) ? due_q0[0] : due_q1[0];
        if (d < cyc) begin
          check($sformatf("p%0d_resp_timeout", p), 96'(cyc), 96'(d));
          if (p == 0) begin void'(exp_q0.pop_front()); void'(due_q0.pop_front()); end
          else        begin void'(exp_q1.pop_front()); void'(due_q1.pop_front()); end
        end
      end
    end
  endtask

  // Reference model: arbitration, busy window and expected responses, evaluated mid-cycle.
  always @(negedge clk) begin : mon
    logic [1:0]  req_v, exp_g;
    logic        p, we, er;
    logic [63:0] a, wd;
    logic [64:0] resp;
    logic [77:0] acc;
    int          d;
    #1;
    if (!rst_n) begin
      exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
      acc_q.delete(); acc_due_q.delete();
      rr = 0; busy = 0;
      for (int k = 0; k < 258; k++) ref_mem[k] = init_val(k);
    end else begin
      req_v = {p1_req, p0_req};
      if (busy > 0) begin
        exp_g = 2'b00;
        busy--;
      end else if (req_v == 2'b11) begin
        exp_g = (rr == 1) ? 2'b10 : 2'b01;
      end else begin
        exp_g = req_v;
      end
      check("gnt", 96'({p1_gnt, p0_gnt}), 96'(exp_g));
      if (exp_g != 2'b00) begin
        p  = exp_g[1];
        we = p ? p1_we : p0_we;
        a  = p ? p1_addr : p0_addr;
        wd = p ? p1_wdata : p0_wdata;
        er = (a >= LIMIT);
        if (er) begin
          resp = {1'b1, 64'd0};
        end else begin
          if (we) begin
            ref_mem[a[8:0]] = wd;
            resp = {1'b0, 64'd0};
          end else begin
            resp = {1'b0, ref_mem[a[8:0]]};
          end
          acc_q.push_back({we, a[12:0], wd});
          acc_due_q.push_back(cyc + 1);
          n_legal++;
        end
        d = cyc + (er ? 1 : LAT + 2);
        if (p == 0) begin exp_q0.push_back(resp); due_q0.push_back(d); end
        else        begin exp_q1.push_back(resp); due_q1.push_back(d); end
        busy = er ? 1 : LAT + 2;
        rr   = p ? 0 : 1;
      end
      if (ram_en) begin
        n_ram_en++;
        if (acc_q.size() == 0) begin
          check("ram_en_spurious", 96'(ram_en), 96'd0);
        end else begin
          acc = acc_q.pop_front();
          d   = acc_due_q.pop_front();
          check("ram_access", 96'({ram_we, ram_addr, ram_wdata}), 96'(acc));
          check("ram_en_cycle", 96'(cyc), 96'(d));
        end
      end
      mon_port(0, p0_rvalid, p0_rdata, p0_err);
      mon_port(1, p1_rvalid, p1_rdata, p1_err);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input int p, input logic we, input logic [63:0] addr, input logic [63:0] wd);
    logic g;
    int   t;
    t = 0;
    if (p == 0) begin p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1; end
    else        begin p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1; end
    forever begin
      #2;
      g = (p == 0) ? p0_gnt : p1_gnt;
      if (g) break;
      t++;
      if (t > 60) begin
        check($sformatf("p%0d_gnt_timeout", p), 96'(g), 96'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 64'($urandom_range(0, 7));
      1:       return 64'($urandom_range(250, 265));
      2:       return 64'($urandom_range(0, 257));
      3:       return {$urandom, $urandom};
      4:       return 64'h1_0000_0000 | 64'($urandom_range(0, 7));
      default: return 64'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic rand_traffic(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(p, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    p0_req = 1'b1;
    p1_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl_outs", 96'({p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, ram_en, ram_we}), 96'd0);
    check("reset_data_outs", 96'({p0_rdata | p1_rdata | ram_wdata, ram_addr}), 96'd0);
    check("reset_state", 96'(dbg_state), 96'(ST_IDLE));
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 1'b1, 64'd5, 64'hDEAD_BEEF);
    issue(0, 1'b0, 64'd5, 64'd0);

    fork
      begin issue(0, 1'b0, 64'd1, 64'd0); issue(0, 1'b0, 64'd1, 64'd0); end
      begin issue(1, 1'b0, 64'd2, 64'd0); issue(1, 1'b0, 64'd2, 64'd0); end
    join

    issue(1, 1'b0, 64'd258, 64'd0);
    issue(1, 1'b0, 64'd257, 64'd0);
    issue(0, 1'b1, 64'h1_0000_0005, 64'h1234_5678_9ABC_DEF0);
    issue(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    issue(0, 1'b0, 64'd5, 64'd0);
    issue(1, 1'b1, 64'd257, 64'hCAFE_F00D_0000_0001);
    issue(0, 1'b0, 64'd257, 64'd0);

    // Requester 0 drops after its grant while requester 1 arrives mid-transaction.
    fork
      issue(0, 1'b0, 64'd3, 64'd0);
      begin @(negedge clk); issue(1, 1'b0, 64'd4, 64'd0); end
    join

    // Reset lands while a read is waiting on the RAM.
    issue(0, 1'b0, 64'd7, 64'd0);
    @(posedge clk);
    p0_req = 1'b1;
    p1_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 96'({p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, ram_en, ram_we}), 96'd0);
    check("async_reset_data", 96'({p0_rdata | p1_rdata | ram_wdata, ram_addr}), 96'd0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      issue(0, 1'b0, 64'd9, 64'd0);
      issue(1, 1'b0, 64'd10, 64'd0);
    join

    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
    join

    repeat (LAT + 6) @(negedge clk);
    check("ram_en_count", 96'(n_ram_en), 96'(n_legal));
    check("p0_pending", 96'(exp_q0.size()), 96'd0);
    check("p1_pending", 96'(exp_q1.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences all accesses to the single-port Y86-64 data memory (8192 x 64-bit words, word-addressed).
- Arbitrates between two requesters:
  - port 0: the memory stage (rmmovq/mrmovq/call/ret/push/pop traffic);
  - port 1: a secondary requester (fetch/debug loader).
- Turns each granted request into a single RAM access with a fixed read latency.
- Flags out-of-range addresses without touching the RAM.

Parameters:
- AW, 13, RAM address width in bits; ram_addr = latched addr[AW-1:0].
- ADDR_LIMIT, 258, first illegal word address; addr >= ADDR_LIMIT is a data-memory error.
- RD_LAT, 1, cycles from the ram_en cycle to valid ram_rdata; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- p0_req  in  1  port 0 request; held with addr/we/wdata stable until p0_gnt.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  64  port 0 word address.
- p0_wdata  in  64  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle (combinational from IDLE + arbitration).
- p0_rvalid  out  1  port 0 response valid, one-cycle pulse.
- p0_rdata  out  64  port 0 read data, valid with p0_rvalid.
- p0_err  out  1  port 0 address error, valid with p0_rvalid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same widths and meaning, for port 1.
- ram_en  out  1  RAM access strobe, one cycle per transaction.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  64  RAM write data.
- ram_rdata  in  64  RAM read data, valid RD_LAT cycles after the ram_en cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; rr_ptr=0 (port 0 favoured); wait counter=0.
  - All outputs 0, including ram_en, rvalid, err and rdata.
- States: IDLE, ACCESS, WAIT, RESP, ERR.
- IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the port indicated by rr_ptr.
  - gnt is high for exactly one cycle. At that clock edge we/addr/wdata and the port id are latched.
  - rr_ptr is set to the other port after every grant.
  - Latched addr >= ADDR_LIMIT (full 64-bit unsigned compare) -> ERR; else -> ACCESS.
- ACCESS (1 cycle):
  - ram_en=1; ram_we=latched we; ram_addr and ram_wdata driven from the latches.
  - -> WAIT with counter=RD_LAT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, ram_rdata is captured into the rdata register. Writes capture 0.
  - -> RESP.
- RESP (1 cycle): rvalid=1 and err=0 on the granted port only; rdata holds the captured value. -> IDLE.
- ERR (1 cycle): rvalid=1, err=1, rdata=0 on the granted port; ram_en stays 0. -> IDLE.
- Latency:
  - Legal access: gnt in cycle 0, ram_en in cycle 1, rvalid in cycle RD_LAT+2.
  - Error access: rvalid in cycle 1.
- Throughput: one transaction in flight. No grant outside IDLE. Back-to-back legal transactions are RD_LAT+3 cycles apart.
- Non-granted port: rvalid/rdata/err stay 0 throughout.
- Request deasserted after gnt: ignored; the transaction completes normally.
- Request held after its rvalid: treated as a new request.
- Reset mid-transaction: transaction aborted, no response. A pending RAM write is lost if reset lands before the ram_en edge.
- RD_LAT outside 1..7: elaboration error.

Decomposition:
- Package y86_mem_pkg:
  - state enum (IDLE/ACCESS/WAIT/RESP/ERR);
  - defaults for ADDR_LIMIT and AW;
  - port index constants PORT_MEM=0, PORT_AUX=1.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs req[1:0], en, ptr; outputs gnt[1:0]; ptr updates on grant.

Test Plan:
- Port 0 write addr=5 wdata=0xDEAD_BEEF, then read addr=5 (RD_LAT=1) -> read p0_rvalid 3 cycles after gnt, p0_rdata=0xDEADBEEF, p0_err=0; exactly one ram_en per transaction.
- p0_req and p1_req held high together for 4 transactions, reads of addr 1 and addr 2 -> grant order 0,1,0,1; each response appears only on its own port with correct data.
- Port 1 read addr=258 -> p1_rvalid=1, p1_err=1, p1_rdata=0 one cycle after gnt; ram_en never asserted. Addr=257 -> err=0 with a normal RAM access.
- RD_LAT=3, port 0 read addr=0 -> ram_en in cycle 1, rvalid in cycle 5; sampled rdata matches ram_rdata from cycle 4.
- Assert rst_n low during WAIT -> all outputs 0 immediately (asynchronous), no rvalid afterwards; next request after release is granted to port 0.
- p0_req dropped the cycle after gnt while p1_req rises -> port 0 response still delivered; port 1 granted only after returning to IDLE.
